// File: rtl/ysyx_lsu.sv
// Load/store unit: turns one EXU memory request into a single AXI4-Lite-style
// read or write transaction, with lane alignment and load extension.
module ysyx_lsu #(
    parameter int unsigned BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_avalid,
    input  logic [BIT_W-1:0] lsu_addr,
    input  logic             lsu_ren,
    input  logic             lsu_wen,
    input  logic [3:0]       lsu_op,
    input  logic [BIT_W-1:0] lsu_wdata,
    output logic [BIT_W-1:0] lsu_rdata_o,
    output logic             lsu_rvalid_o,
    output logic             lsu_wready_o,
    output logic             lsu_err_o,
    output logic [BIT_W-1:0] bus_araddr_o,
    output logic             bus_arvalid_o,
    input  logic             bus_arready,
    input  logic [BIT_W-1:0] bus_rdata,
    input  logic [1:0]       bus_rresp,
    input  logic             bus_rvalid,
    output logic             bus_rready_o,
    output logic [BIT_W-1:0] bus_awaddr_o,
    output logic             bus_awvalid_o,
    input  logic             bus_awready,
    output logic [BIT_W-1:0] bus_wdata_o,
    output logic [3:0]       bus_wstrb_o,
    output logic             bus_wvalid_o,
    input  logic             bus_wready,
    input  logic [1:0]       bus_bresp,
    input  logic             bus_bvalid,
    output logic             bus_bready_o
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR,
        S_WR_B,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   addr_q, addr_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [BIT_W-1:0]   rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               wready_q, wready_d;
    logic               err_q, err_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic [BIT_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               bready_q, bready_d;

    logic               unused_op3;
    assign unused_op3 = lsu_op[3];

    // State and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            wready_q  <= wready_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        logic             is_h;
        logic             is_w;
        logic             bad;
        logic             aw_pend;
        logic             w_pend;
        logic [3:0]       strb_base;
        logic [BIT_W-1:0] rshift;
        logic [BIT_W-1:0] ld_val;

        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        wready_d  = 1'b0;
        err_d     = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bready_d  = bready_q;

        is_h      = (lsu_op[1:0] == 2'b01);
        is_w      = lsu_op[1];
        bad       = (is_h && lsu_addr[0]) || (is_w && (lsu_addr[1:0] != 2'b00))
                    || (lsu_ren == lsu_wen);
        aw_pend   = awvalid_q && !bus_awready;
        w_pend    = wvalid_q && !bus_wready;
        strb_base = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);

        // Right-justify the addressed lanes, then extend by funct3
        rshift = bus_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'b000:  ld_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ld_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ld_val = {24'b0, rshift[7:0]};
            3'b101:  ld_val = {16'b0, rshift[15:0]};
            default: ld_val = rshift;
        endcase

        case (state_q)
            S_IDLE: begin
                if (lsu_avalid) begin
                    addr_d = lsu_addr;
                    op_d   = lsu_op[OP_W-1:0];
                    if (bad) begin
                        state_d  = S_RESP;
                        err_d    = 1'b1;
                        wready_d = lsu_wen;
                        rvalid_d = !lsu_wen;
                    end else if (lsu_ren) begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        wstrb_d   = strb_base << lsu_addr[1:0];
                        if (is_w)      wdata_d = lsu_wdata;
                        else if (is_h) wdata_d = {2{lsu_wdata[15:0]}};
                        else           wdata_d = {4{lsu_wdata[7:0]}};
                    end
                end
            end
            S_RD_A: begin
                if (bus_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                if (bus_rvalid) begin
                    rready_d = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = (bus_rresp != 2'b00);
                    if (bus_rresp == 2'b00) rdata_d = ld_val;
                    state_d  = S_RESP;
                end
            end
            S_WR: begin
                // Address and data channels retire independently
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (bus_bvalid) begin
                    bready_d = 1'b0;
                    wready_d = 1'b1;
                    err_d    = (bus_bresp != 2'b00);
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign lsu_rdata_o   = rdata_q;
    assign lsu_rvalid_o  = rvalid_q;
    assign lsu_wready_o  = wready_q;
    assign lsu_err_o     = err_q;
    assign bus_araddr_o  = addr_q;
    assign bus_arvalid_o = arvalid_q;
    assign bus_rready_o  = rready_q;
    assign bus_awaddr_o  = addr_q;
    assign bus_awvalid_o = awvalid_q;
    assign bus_wdata_o   = wdata_q;
    assign bus_wstrb_o   = wstrb_q;
    assign bus_wvalid_o  = wvalid_q;
    assign bus_bready_o  = bready_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: cycle-accurate checks of loads, stores,
// faults, bus wait states and reset during a transaction.
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_avalid;
    logic [31:0] lsu_addr;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [3:0]  lsu_op;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_wready_o;
    logic        lsu_err_o;
    logic [31:0] bus_araddr_o;
    logic        bus_arvalid_o;
    logic        bus_arready;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_rresp;
    logic        bus_rvalid;
    logic        bus_rready_o;
    logic [31:0] bus_awaddr_o;
    logic        bus_awvalid_o;
    logic        bus_awready;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_wvalid_o;
    logic        bus_wready;
    logic [1:0]  bus_bresp;
    logic        bus_bvalid;
    logic        bus_bready_o;

    int n_pass  = 0;
    int n_total = 0;

    // {rvalid, wready, err, arvalid, rready, awvalid, wvalid, bready}
    logic [7:0] ctl;
    assign ctl = {lsu_rvalid_o, lsu_wready_o, lsu_err_o, bus_arvalid_o,
                  bus_rready_o, bus_awvalid_o, bus_wvalid_o, bus_bready_o};

    always #5 clk = ~clk;

    ysyx_lsu #(.BIT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .lsu_avalid    (lsu_avalid),
        .lsu_addr      (lsu_addr),
        .lsu_ren       (lsu_ren),
        .lsu_wen       (lsu_wen),
        .lsu_op        (lsu_op),
        .lsu_wdata     (lsu_wdata),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_rvalid_o  (lsu_rvalid_o),
        .lsu_wready_o  (lsu_wready_o),
        .lsu_err_o     (lsu_err_o),
        .bus_araddr_o  (bus_araddr_o),
        .bus_arvalid_o (bus_arvalid_o),
        .bus_arready   (bus_arready),
        .bus_rdata     (bus_rdata),
        .bus_rresp     (bus_rresp),
        .bus_rvalid    (bus_rvalid),
        .bus_rready_o  (bus_rready_o),
        .bus_awaddr_o  (bus_awaddr_o),
        .bus_awvalid_o (bus_awvalid_o),
        .bus_awready   (bus_awready),
        .bus_wdata_o   (bus_wdata_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_wvalid_o  (bus_wvalid_o),
        .bus_wready    (bus_wready),
        .bus_bresp     (bus_bresp),
        .bus_bvalid    (bus_bvalid),
        .bus_bready_o  (bus_bready_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_arready = 1'b0;
        bus_rdata   = '0;
        bus_rresp   = 2'b00;
        bus_rvalid  = 1'b0;
        bus_awready = 1'b0;
        bus_wready  = 1'b0;
        bus_bresp   = 2'b00;
        bus_bvalid  = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] op, input logic [31:0] wd);
        lsu_avalid = 1'b1;
        lsu_addr   = a;
        lsu_ren    = r;
        lsu_wen    = w;
        lsu_op     = op;
        lsu_wdata  = wd;
    endtask

    task automatic drop();
        lsu_avalid = 1'b0;
        lsu_ren    = 1'b0;
        lsu_wen    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drop();
        lsu_addr  = '0;
        lsu_op    = '0;
        lsu_wdata = '0;
        bus_idle();
        step();
        step();
        n_total++;
        if (ctl !== 8'h00) $display("FAIL reset_ctl: got %b expected %b", ctl, 8'h00);
        else n_pass++;
        n_total++;
        if ({lsu_rdata_o, bus_araddr_o, bus_wdata_o, bus_wstrb_o} !== 100'd0)
            $display("FAIL reset_data: got %h %h %h %h expected zeros",
                     lsu_rdata_o, bus_araddr_o, bus_wdata_o, bus_wstrb_o);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_lb_sign();
        req(32'h8000_0003, 1'b1, 1'b0, 4'b0000, 32'h0);
        step();                                   // cycle 1
        n_total++;
        if (ctl !== 8'b0001_0000 || bus_araddr_o !== 32'h8000_0003)
            $display("FAIL lb_ar: got %b %h expected 00010000 80000003", ctl, bus_araddr_o);
        else n_pass++;
        bus_arready = 1'b1;
        step();                                   // cycle 2
        n_total++;
        if (ctl !== 8'b0000_1000) $display("FAIL lb_rready: got %b expected 00001000", ctl);
        else n_pass++;
        bus_arready = 1'b0;
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'h80FF_1234;
        step();                                   // cycle 3
        n_total++;
        if (ctl !== 8'b1000_0000 || lsu_rdata_o !== 32'hFFFF_FF80)
            $display("FAIL lb_resp: got %b %h expected 10000000 ffffff80", ctl, lsu_rdata_o);
        else n_pass++;
        drop();
        bus_idle();
        step();
        n_total++;
        if (ctl !== 8'h00) $display("FAIL lb_single_pulse: got %b expected 00000000", ctl);
        else n_pass++;
    endtask

    task automatic test_lhu_wait();
        req(32'h8000_0002, 1'b1, 1'b0, 4'b0101, 32'h0);
        step();                                   // cycle 1
        bus_arready = 1'b1;
        step();                                   // cycle 2
        bus_arready = 1'b0;
        for (int i = 0; i < 5; i++) step();       // cycles 3..7, rvalid low
        n_total++;
        if (ctl !== 8'b0000_1000) $display("FAIL lhu_stall: got %b expected 00001000", ctl);
        else n_pass++;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h80FF_1234;
        step();                                   // cycle 8
        n_total++;
        if (ctl !== 8'b1000_0000 || lsu_rdata_o !== 32'h0000_80FF)
            $display("FAIL lhu_resp: got %b %h expected 10000000 000080ff", ctl, lsu_rdata_o);
        else n_pass++;
        drop();
        bus_idle();
        step();
    endtask

    task automatic test_sb_lanes();
        req(32'h8000_0001, 1'b0, 1'b1, 4'b0000, 32'h1234_56AB);
        step();                                   // cycle 1
        n_total++;
        if (ctl !== 8'b0000_0110 || bus_wstrb_o !== 4'b0010 ||
            bus_wdata_o !== 32'hABAB_ABAB || bus_awaddr_o !== 32'h8000_0001)
            $display("FAIL sb_aw_w: got %b %b %h %h expected 00000110 0010 abababab 80000001",
                     ctl, bus_wstrb_o, bus_wdata_o, bus_awaddr_o);
        else n_pass++;
        bus_wready = 1'b1;
        step();                                   // cycle 2
        n_total++;
        if (ctl !== 8'b0000_0100) $display("FAIL sb_w_first: got %b expected 00000100", ctl);
        else n_pass++;
        bus_wready = 1'b0;
        step();                                   // cycle 3
        n_total++;
        if (ctl !== 8'b0000_0100 || bus_awaddr_o !== 32'h8000_0001)
            $display("FAIL sb_aw_hold: got %b %h expected 00000100 80000001", ctl, bus_awaddr_o);
        else n_pass++;
        bus_awready = 1'b1;
        step();                                   // cycle 4
        n_total++;
        if (ctl !== 8'b0000_0001) $display("FAIL sb_bready: got %b expected 00000001", ctl);
        else n_pass++;
        bus_awready = 1'b0;
        bus_bvalid  = 1'b1;
        step();                                   // cycle 5
        n_total++;
        if (ctl !== 8'b0100_0000) $display("FAIL sb_resp: got %b expected 01000000", ctl);
        else n_pass++;
        drop();
        bus_idle();
        step();
    endtask

    task automatic test_misaligned();
        req(32'h8000_0001, 1'b0, 1'b1, 4'b0001, 32'h0000_BEEF);
        step();                                   // cycle 1
        n_total++;
        if (ctl !== 8'b0110_0000) $display("FAIL sh_misaligned: got %b expected 01100000", ctl);
        else n_pass++;
        drop();
        step();
        n_total++;
        if (ctl !== 8'h00) $display("FAIL sh_misaligned_quiet: got %b expected 00000000", ctl);
        else n_pass++;
        req(32'h8000_0006, 1'b1, 1'b0, 4'b0010, 32'h0);
        step();
        n_total++;
        if (ctl !== 8'b1010_0000) $display("FAIL lw_misaligned: got %b expected 10100000", ctl);
        else n_pass++;
        drop();
        step();
    endtask

    task automatic test_illegal_dir();
        req(32'h8000_0000, 1'b1, 1'b1, 4'b0010, 32'h0);
        step();
        n_total++;
        if (ctl !== 8'b0110_0000) $display("FAIL both_dir: got %b expected 01100000", ctl);
        else n_pass++;
        drop();
        step();
        req(32'h8000_0000, 1'b0, 1'b0, 4'b0010, 32'h0);
        step();
        n_total++;
        if (ctl !== 8'b1010_0000) $display("FAIL no_dir: got %b expected 10100000", ctl);
        else n_pass++;
        drop();
        step();
    endtask

    task automatic test_bus_err();
        req(32'h8000_0004, 1'b1, 1'b0, 4'b0010, 32'h0);
        step();
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'h1111_1111;
        bus_rresp   = 2'b10;
        step();
        n_total++;
        if (ctl !== 8'b1010_0000 || lsu_rdata_o !== 32'h0000_80FF)
            $display("FAIL load_bus_err: got %b %h expected 10100000 000080ff", ctl, lsu_rdata_o);
        else n_pass++;
        drop();
        bus_idle();
        step();
    endtask

    task automatic store_zero_wait(input logic [31:0] a, input logic [3:0] op,
                                   input logic [31:0] wd, input logic [3:0] exp_strb,
                                   input logic [31:0] exp_wd);
        req(a, 1'b0, 1'b1, op, wd);
        step();
        n_total++;
        if (ctl !== 8'b0000_0110 || bus_wstrb_o !== exp_strb || bus_wdata_o !== exp_wd)
            $display("FAIL b2b_store_lanes: got %b %b %h expected 00000110 %b %h",
                     ctl, bus_wstrb_o, bus_wdata_o, exp_strb, exp_wd);
        else n_pass++;
        bus_awready = 1'b1;
        bus_wready  = 1'b1;
        step();
        bus_awready = 1'b0;
        bus_wready  = 1'b0;
        bus_bvalid  = 1'b1;
        step();
        n_total++;
        if (ctl !== 8'b0100_0000) $display("FAIL b2b_store_resp: got %b expected 01000000", ctl);
        else n_pass++;
        drop();
        bus_idle();
    endtask

    task automatic test_back_to_back();
        store_zero_wait(32'h8000_0004, 4'b0010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        step();
        store_zero_wait(32'h8000_0002, 4'b0001, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        step();
    endtask

    task automatic test_reset_midflight();
        req(32'h8000_0008, 1'b1, 1'b0, 4'b0010, 32'h0);
        step();
        bus_arready = 1'b1;
        step();                                   // now in RD_D
        bus_arready = 1'b0;
        rst = 1'b1;
        step();
        n_total++;
        if (ctl !== 8'h00 || lsu_rdata_o !== 32'h0)
            $display("FAIL rst_mid: got %b %h expected 00000000 00000000", ctl, lsu_rdata_o);
        else n_pass++;
        rst = 1'b0;
        drop();
        step();
        req(32'h8000_0000, 1'b1, 1'b0, 4'b0010, 32'h0);
        step();
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'hDEAD_BEEF;
        step();
        n_total++;
        if (ctl !== 8'b1000_0000 || lsu_rdata_o !== 32'hDEAD_BEEF)
            $display("FAIL rst_then_lw: got %b %h expected 10000000 deadbeef", ctl, lsu_rdata_o);
        else n_pass++;
        drop();
        bus_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_lhu_wait();
        test_sb_lanes();
        test_misaligned();
        test_illegal_dir();
        test_bus_err();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_lsu.md
# ysyx_lsu

Load/store unit that services the EXU's single outstanding memory request. It receives address, width/sign op, store data and direction from the EXU, and runs one AXI4-Lite-style transaction on the data bus. It aligns store lanes and extracts and extends load data, then returns one response pulse (`lsu_rvalid_o` for loads, `lsu_wready_o` for stores). It sits between the EXU and the data-side bus arbiter.

## Interface
- `BIT_W`, 32: data/address width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `lsu_avalid`  in  1  request valid from EXU; held high until the response pulse is seen.
- `lsu_addr`  in  BIT_W  byte address.
- `lsu_ren`  in  1  load request.
- `lsu_wen`  in  1  store request.
- `lsu_op`  in  4  bits [2:0] = RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; bit 3 ignored.
- `lsu_wdata`  in  BIT_W  store data, LSB-aligned.
- `lsu_rdata_o`  out  BIT_W  aligned, extended load result; holds until the next load completes.
- `lsu_rvalid_o`  out  1  one-cycle load-done pulse.
- `lsu_wready_o`  out  1  one-cycle store-done pulse.
- `lsu_err_o`  out  1  high with the done pulse when the access faulted.
- `bus_araddr_o` out BIT_W; `bus_arvalid_o` out 1; `bus_arready` in 1.
- `bus_rdata` in BIT_W; `bus_rresp` in 2; `bus_rvalid` in 1; `bus_rready_o` out 1.
- `bus_awaddr_o` out BIT_W; `bus_awvalid_o` out 1; `bus_awready` in 1.
- `bus_wdata_o` out BIT_W; `bus_wstrb_o` out 4; `bus_wvalid_o` out 1; `bus_wready` in 1.
- `bus_bresp` in 2; `bus_bvalid` in 1; `bus_bready_o` out 1.

## Operation
- States: IDLE, RD_A, RD_D, WR, WR_B, RESP.
- **IDLE, accepting a request:** when `lsu_avalid` is high, latch addr, op, wdata and direction.
- **IDLE, decode:**
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0), or `lsu_ren` and `lsu_wen` both high, or neither high: go to RESP with err=1 and no bus traffic. The pulse type follows `lsu_wen`; if neither is set, pulse `lsu_rvalid_o`.
  - Load: go to RD_A.
  - Store: go to WR.
- **RD_A:** `bus_arvalid_o`=1, `bus_araddr_o`=latched addr (unaligned byte address passed through). On `bus_arready` go to RD_D.
- **RD_D:** `bus_rready_o`=1. On `bus_rvalid`:
  - shift `bus_rdata` right by addr[1:0]*8;
  - sign- or zero-extend by op; W passes through;
  - write the result to `lsu_rdata_o`;
  - err = (`bus_rresp`≠00);
  - go to RESP.
- **WR:** `bus_awvalid_o` and `bus_wvalid_o` are both asserted on entry.
  - Each drops independently after its own handshake; they may complete in either order or in the same cycle.
  - When both are done, go to WR_B.
  - `bus_wstrb_o`: B=0001, H=0011, W=1111, shifted left by addr[1:0].
  - `bus_wdata_o`: store data replicated per lane (B: {4{b}}, H: {2{h}}, W: as is).
- **WR_B:** `bus_bready_o`=1. On `bus_bvalid`, err = (`bus_bresp`≠00); go to RESP.
- **RESP:**
  - Exactly one of `lsu_rvalid_o`/`lsu_wready_o` is high, with `lsu_err_o` valid.
  - `lsu_avalid` is ignored this cycle (EXU drops it on this edge).
  - Next state is IDLE.
- On a faulted load, `lsu_rdata_o` is left unchanged.
- Bus address/data outputs are stable while their valid is high.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE.
- Zero-wait load: request in cycle 0; `bus_arvalid_o` cycle 1; `bus_rready_o` cycle 2; `lsu_rvalid_o` cycle 3.
- Zero-wait store: request in cycle 0; aw/w in cycle 1; `bus_bready_o` cycle 2; `lsu_wready_o` cycle 3.
- Misaligned or illegal request: done pulse in cycle 1.
- Back-to-back requests: the earliest acceptance of the next request is the cycle after RESP.
- Wait states of any length on arready, rvalid, awready, wready or bvalid stall in the current state with no timeout.
- Bus valid signals never drop before their handshake, except on reset.
- Reset mid-transaction: every valid/ready output is 0 in the cycle after reset is sampled, state IDLE, and no response pulse. An abandoned bus transaction is acceptable.
- Exactly one response per accepted request; no response without a request.

## Test plan
- **LB, sign extend:** addr 0x8000_0003, `bus_rdata` 0x80FF_1234, zero wait -> `lsu_rdata_o`=0xFFFF_FF80; `lsu_rvalid_o` in cycle 3; err 0.
- **LHU, zero extend:** addr 0x8000_0002, `bus_rdata` 0x80FF_1234, `bus_rvalid` delayed 5 cycles -> `lsu_rdata_o`=0x0000_80FF, pulse 5 cycles later than zero-wait.
- **SB lane placement:** addr 0x8000_0001, wdata 0x1234_56AB -> `bus_wstrb_o`=0010, `bus_wdata_o`=0xABAB_ABAB. With `bus_awready` 2 cycles after `bus_wready`: `bus_wvalid_o` drops first and `bus_awvalid_o` stays high until its handshake; `lsu_wready_o` one cycle after `bus_bvalid`.
- **Misaligned store:** SH at 0x8000_0001 -> no bus valid ever asserted; `lsu_wready_o`=1 and `lsu_err_o`=1 in cycle 1.
- **Bus error:** load with `bus_rresp`=10 -> `lsu_rvalid_o`=1, `lsu_err_o`=1, `lsu_rdata_o` unchanged.
- **Reset mid-flight:** `rst` asserted while in RD_D -> next cycle all outputs 0; a new LW at 0x8000_0000 then completes normally with `bus_rdata` 0xDEAD_BEEF -> `lsu_rdata_o`=0xDEAD_BEEF.
